// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ctrl
// Description : Pin-level write driver for an HD44780-compatible character
//               LCD. After reset it waits out the panel power-up time and
//               sends the four-command init sequence. It then executes
//               firmware write requests: each request is an RS/DATA pair
//               plus a toggled REQ bit.
//
// Ports       : i_clk        system clock, rising edge
//               i_rst_n      synchronous active-low reset
//               i_io_lcd     LSU LCD register: [31] ON, [11] REQ toggle,
//                            [9] RS, [7:0] DATA (other bits ignored)
//               o_lcd_on     panel/backlight enable (i_io_lcd[31], 1 cycle)
//               o_lcd_en     LCD EN strobe
//               o_lcd_rs     LCD register select
//               o_lcd_rw     LCD read/write, tied to write
//               o_lcd_data   LCD data bus
//               o_busy       init or a transaction in progress
//               o_ack        REQ value of the last completed request
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ctrl #(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_SHORT = 2000,
    parameter int T_LONG  = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_io_lcd,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_busy,
    output logic        o_ack
);

    // One shared counter serves every timed state. It is wide enough for
    // the longest delay, which includes the power-up wait.
    localparam int c_T_MAX_A = (T_PWRUP > T_LONG)  ? T_PWRUP : T_LONG;
    localparam int c_T_MAX_B = (T_SHORT > T_EN)    ? T_SHORT : T_EN;
    localparam int c_T_MAX_C = (T_SETUP > T_HOLD)  ? T_SETUP : T_HOLD;
    localparam int c_T_MAX_D = (c_T_MAX_A > c_T_MAX_B) ? c_T_MAX_A : c_T_MAX_B;
    localparam int c_T_MAX   = (c_T_MAX_D > c_T_MAX_C) ? c_T_MAX_D : c_T_MAX_C;
    localparam int c_CW      = $clog2(c_T_MAX + 1);

    localparam logic [2:0] c_PWRUP = 3'd0;
    localparam logic [2:0] c_INIT  = 3'd1;
    localparam logic [2:0] c_SETUP = 3'd2;
    localparam logic [2:0] c_EN_HI = 3'd3;
    localparam logic [2:0] c_HOLD  = 3'd4;
    localparam logic [2:0] c_WAIT  = 3'd5;
    localparam logic [2:0] c_IDLE  = 3'd6;

    logic [2:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_idx;
    logic            r_init;
    logic            r_rs;
    logic [7:0]      r_data;
    logic            r_req;
    logic            r_req_seen;
    logic            r_ack;
    logic            r_en;
    logic            r_busy;
    logic            r_on;

    logic [c_CW-1:0] w_dur;
    logic            w_done;
    logic            w_long;
    logic [7:0]      w_rom;
    logic            w_unused;

    // Only ON, REQ, RS and DATA are meaningful in the LSU register.
    assign w_unused = ^{i_io_lcd[30:12], i_io_lcd[10], i_io_lcd[8]};

    // Clear display (0x01) needs the long execution wait.
    assign w_long = (r_rs == 1'b0) && (r_data[7:1] == 7'd0) && (r_data != 8'd0);

    always_comb begin
        w_dur = c_CW'(1);
        case (r_state)
            c_PWRUP: w_dur = c_CW'(T_PWRUP);
            c_SETUP: w_dur = c_CW'(T_SETUP);
            c_EN_HI: w_dur = c_CW'(T_EN);
            c_HOLD:  w_dur = c_CW'(T_HOLD);
            c_WAIT:  w_dur = w_long ? c_CW'(T_LONG) : c_CW'(T_SHORT);
            default: w_dur = c_CW'(1);
        endcase
    end

    // The counter starts at 0 on state entry; the state has lasted w_dur
    // cycles when the count reaches w_dur-1, so it never wraps.
    assign w_done = (r_cnt == (w_dur - c_CW'(1)));

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    always_comb begin
        w_rom = 8'h38;
        case (r_idx)
            2'd0:    w_rom = 8'h38;
            2'd1:    w_rom = 8'h0C;
            2'd2:    w_rom = 8'h01;
            default: w_rom = 8'h06;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= c_PWRUP;
            r_cnt      <= '0;
            r_idx      <= 2'd0;
            r_init     <= 1'b1;
            r_rs       <= 1'b0;
            r_data     <= 8'd0;
            r_req      <= 1'b0;
            r_req_seen <= 1'b0;
            r_ack      <= 1'b0;
            r_en       <= 1'b0;
            r_busy     <= 1'b1;
            r_on       <= 1'b0;
        end else begin
            r_on <= i_io_lcd[31];
            case (r_state)
                c_PWRUP: begin
                    if (w_done) begin
                        r_state <= c_INIT;
                        r_cnt   <= '0;
                        r_idx   <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_INIT: begin
                    r_rs    <= 1'b0;
                    r_data  <= w_rom;
                    r_state <= c_SETUP;
                    r_cnt   <= '0;
                end
                c_SETUP: begin
                    if (w_done) begin
                        r_state <= c_EN_HI;
                        r_cnt   <= '0;
                        r_en    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_EN_HI: begin
                    if (w_done) begin
                        r_state <= c_HOLD;
                        r_cnt   <= '0;
                        r_en    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_HOLD: begin
                    if (w_done) begin
                        r_state <= c_WAIT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_WAIT: begin
                    if (w_done) begin
                        r_cnt <= '0;
                        if (r_init && (r_idx != 2'd3)) begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= c_INIT;
                        end else begin
                            // Init completion leaves o_ack alone; only a
                            // firmware request is acknowledged.
                            if (!r_init) begin
                                r_ack <= r_req;
                            end
                            r_init  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_IDLE: begin
                    if (i_io_lcd[11] != r_req_seen) begin
                        r_rs       <= i_io_lcd[9];
                        r_data     <= i_io_lcd[7:0];
                        r_req      <= i_io_lcd[11];
                        r_req_seen <= i_io_lcd[11];
                        r_busy     <= 1'b1;
                        r_state    <= c_SETUP;
                        r_cnt      <= '0;
                    end
                end
                default: begin
                    r_state <= c_PWRUP;
                    r_cnt   <= '0;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign o_lcd_on   = r_on;
    assign o_lcd_en   = r_en;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = r_data;
    assign o_busy     = r_busy;
    assign o_ack      = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_ctrl
// Description : Self-checking bench for lcd_ctrl. A reference timeline of
//               expected EN pulses and busy-fall events is computed from
//               the timing rules and compared with what the pins show.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_ctrl;

    localparam int T_PWRUP = 20;
    localparam int T_SETUP = 2;
    localparam int T_EN    = 3;
    localparam int T_HOLD  = 2;
    localparam int T_SHORT = 10;
    localparam int T_LONG  = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tb_on, tb_req, tb_rs;
    logic [7:0]  tb_data;
    logic [31:0] w_io;
    logic        o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_busy, o_ack;
    logic [7:0]  o_lcd_data;

    always #5 clk = ~clk;

    assign w_io = {tb_on, 19'd0, tb_req, 1'b0, tb_rs, 1'b0, tb_data};

    lcd_ctrl #(
        .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_EN(T_EN),
        .T_HOLD(T_HOLD), .T_SHORT(T_SHORT), .T_LONG(T_LONG)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_io_lcd   (w_io),
        .o_lcd_on   (o_lcd_on),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_data (o_lcd_data),
        .o_busy     (o_busy),
        .o_ack      (o_ack)
    );

    typedef struct {
        int         rise;
        int         fall;
        logic       rs;
        logic [7:0] data;
        logic       stable;
    } pulse_t;

    typedef struct {
        int   cyc;
        logic ack;
    } bfall_t;

    pulse_t obs_p[$];
    pulse_t exp_p[$];
    bfall_t obs_b[$];
    bfall_t exp_b[$];

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;
    int rw_bad      = 0;
    int on_bad      = 0;
    bit done        = 0;

    // ---------------- pin monitor ----------------
    logic       prev_en   = 1'b0;
    logic       prev_busy = 1'b1;
    logic       in_p      = 1'b0;
    int         hold_left = 0;
    pulse_t     cur;
    logic [8:0] hist [T_SETUP];

    always @(posedge clk) begin
        logic on_s;
        logic rst_s;
        cyc++;
        on_s  = tb_on;
        rst_s = rst_n;
        #1;
        if (o_lcd_on !== (rst_s ? on_s : 1'b0)) on_bad++;
        if (o_lcd_rw !== 1'b0) rw_bad++;
        if (!rst_s) begin
            in_p      = 1'b0;
            hold_left = 0;
        end else begin
            if (o_lcd_en && !prev_en) begin
                cur.rise   = cyc;
                cur.fall   = 0;
                cur.rs     = o_lcd_rs;
                cur.data   = o_lcd_data;
                cur.stable = 1'b1;
                for (int i = 0; i < T_SETUP; i++)
                    if (hist[i] !== {o_lcd_rs, o_lcd_data}) cur.stable = 1'b0;
                in_p = 1'b1;
            end else if (in_p) begin
                if ({o_lcd_rs, o_lcd_data} !== {cur.rs, cur.data}) cur.stable = 1'b0;
                if (!o_lcd_en && prev_en) begin
                    cur.fall  = cyc;
                    hold_left = T_HOLD;
                end
                if (hold_left > 0) begin
                    hold_left--;
                    if (hold_left == 0) begin
                        obs_p.push_back(cur);
                        in_p = 1'b0;
                    end
                end
            end
            if (!o_busy && prev_busy) obs_b.push_back('{cyc, o_ack});
        end
        for (int i = T_SETUP - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0]   = {o_lcd_rs, o_lcd_data};
        prev_en   = o_lcd_en;
        prev_busy = o_busy;
    end

    // Panel enable is toggled at random throughout, including power-up.
    initial begin
        while (!done) begin
            @(posedge clk);
            #3;
            if ($urandom_range(0, 3) == 0) tb_on = ~tb_on;
        end
    end

    // ---------------- checking and reference model ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One write cycle whose SETUP phase begins at edge s.
    task automatic model(input int s, input logic rs, input logic [7:0] d,
                         input logic ack, input bit ends_busy, output int t_end);
        pulse_t p;
        int     w;
        w = (rs == 1'b0 && d[7:1] == 7'd0 && d != 8'd0) ? T_LONG : T_SHORT;
        p.rise   = s + T_SETUP;
        p.fall   = p.rise + T_EN;
        p.rs     = rs;
        p.data   = d;
        p.stable = 1'b1;
        exp_p.push_back(p);
        t_end = p.fall + T_HOLD + w;
        if (ends_busy) exp_b.push_back('{t_end, ack});
    endtask

    // Init after the last reset edge k: power-up wait, then 4 commands,
    // each preceded by one cycle of command load.
    task automatic model_init(input int k);
        logic [7:0] cmds [4];
        int s, e;
        cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
        s = k + T_PWRUP + 1;
        for (int i = 0; i < 4; i++) begin
            model(s, 1'b0, cmds[i], 1'b0, (i == 3), e);
            s = e + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (o_busy !== 1'b0 && n < budget);
        chk("idle_reach", o_busy, 1'b0);
    endtask

    task automatic compare_all(input string tag);
        pulse_t po, pe;
        bfall_t bo, be;
        repeat (3) step();
        chk({tag, "_npulse"}, obs_p.size(), exp_p.size());
        while (obs_p.size() > 0 && exp_p.size() > 0) begin
            po = obs_p.pop_front();
            pe = exp_p.pop_front();
            chk({tag, "_rise"},   po.rise,   pe.rise);
            chk({tag, "_fall"},   po.fall,   pe.fall);
            chk({tag, "_rs"},     po.rs,     pe.rs);
            chk({tag, "_data"},   po.data,   pe.data);
            chk({tag, "_stable"}, po.stable, pe.stable);
        end
        chk({tag, "_nbusyfall"}, obs_b.size(), exp_b.size());
        while (obs_b.size() > 0 && exp_b.size() > 0) begin
            bo = obs_b.pop_front();
            be = exp_b.pop_front();
            chk({tag, "_busyfall_cyc"}, bo.cyc, be.cyc);
            chk({tag, "_ack"},          bo.ack, be.ack);
        end
        obs_p.delete(); exp_p.delete(); obs_b.delete(); exp_b.delete();
    endtask

    task automatic clear_q();
        obs_p.delete(); exp_p.delete(); obs_b.delete(); exp_b.delete();
    endtask

    // Issue a request; the accept edge is the next one, where SETUP begins.
    task automatic do_req(input logic rs, input logic [7:0] d, output int t_end);
        tb_req  = ~tb_req;
        tb_rs   = rs;
        tb_data = d;
        model(cyc + 1, rs, d, tb_req, 1'b1, t_end);
        step();
        tb_rs   = logic'($urandom_range(0, 1));
        tb_data = 8'($urandom);
    endtask

    task automatic do_reset(input int n);
        int k;
        step();
        rst_n  = 1'b0;
        tb_req = 1'b0;
        repeat (n) step();
        chk("rst_en",   o_lcd_en,   1'b0);
        chk("rst_busy", o_busy,     1'b1);
        chk("rst_ack",  o_ack,      1'b0);
        chk("rst_rs",   o_lcd_rs,   1'b0);
        chk("rst_data", o_lcd_data, 8'h00);
        k = cyc;
        rst_n = 1'b1;
        clear_q();
        model_init(k);
    endtask

    initial begin
        int e, e2, n, k;
        logic       rs;
        logic [7:0] d;
        rst_n = 1'b0; tb_on = 1'b0; tb_req = 1'b0; tb_rs = 1'b0; tb_data = 8'h00;

        // Power-up and init sequence.
        do_reset(3);
        wait_idle(500);
        compare_all("init");

        // Single data write.
        do_req(1'b1, 8'h41, e);
        wait_idle(200);
        chk("ack_41", o_ack, tb_req);
        compare_all("req41");

        // Clear (long wait) followed by set-DDRAM (short wait).
        do_req(1'b0, 8'h01, e);
        wait_idle(200);
        do_req(1'b0, 8'h80, e);
        wait_idle(200);
        compare_all("clr_then_cmd");

        // Toggle during a transaction with new data: in-flight bus keeps
        // the latched value, the new request runs on return to IDLE.
        do_req(1'b1, 8'h41, e);
        n = 0;
        while (o_lcd_en !== 1'b1 && n < 50) begin step(); n++; end
        chk("ovl_en_seen", o_lcd_en, 1'b1);
        tb_req  = ~tb_req;
        tb_rs   = 1'b1;
        tb_data = 8'h42;
        model(e + 1, 1'b1, 8'h42, tb_req, 1'b1, e2);
        wait_idle(200);
        repeat (2) step();
        wait_idle(200);
        chk("ovl_ack", o_ack, tb_req);
        compare_all("overlap");

        // Double toggle while busy is a net no-op.
        do_req(1'b1, 8'h33, e);
        step();
        tb_req = ~tb_req;
        repeat (2) step();
        tb_req = ~tb_req;
        wait_idle(200);
        repeat (5) step();
        chk("dbl_still_idle", o_busy, 1'b0);
        compare_all("dbl_toggle");

        // Randomized requests; some are forced to the clear command.
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                rs = 1'b0; d = 8'h01;
            end else begin
                rs = logic'($urandom_range(0, 1)); d = 8'($urandom);
            end
            repeat ($urandom_range(0, 3)) step();
            do_req(rs, d, e);
            wait_idle(200);
        end
        compare_all("random");

        // Reset while EN is high: EN drops at once, init repeats.
        do_req(1'b1, 8'h55, e);
        n = 0;
        while (o_lcd_en !== 1'b1 && n < 50) begin step(); n++; end
        chk("mid_en_seen", o_lcd_en, 1'b1);
        rst_n  = 1'b0;
        tb_req = 1'b0;
        step();
        chk("mid_rst_en",   o_lcd_en, 1'b0);
        chk("mid_rst_busy", o_busy,   1'b1);
        chk("mid_rst_ack",  o_ack,    1'b0);
        k = cyc;
        rst_n = 1'b1;
        clear_q();
        model_init(k);
        wait_idle(500);
        compare_all("reinit");

        chk("rw_high_cycles", rw_bad, 0);
        chk("on_miss_cycles", on_bad, 0);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
